// File: rtl/ex_mem_req_ctrl.sv
// ex_mem_req_ctrl: EX-stage data-memory request controller on an SRAM-like bus, in-order tags, flush discard.
// Optional misaligned-address trap enabled by defining MEM_ALE_CHECK_EN.
module ex_mem_req_ctrl #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MAX_OUTST = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                ex_valid,
  output logic                ex_ready,
  input  logic                ex_is_store,
  input  logic [1:0]          ex_size,
  input  logic [ADDR_W-1:0]   ex_addr,
  input  logic [DATA_W-1:0]   ex_wdata,
  input  logic                ex_cancel,
  output logic                req,
  output logic                wr,
  output logic [1:0]          size,
  output logic [DATA_W/8-1:0] wstrb,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   wdata,
  input  logic                addr_ok,
  input  logic                data_ok,
  input  logic [DATA_W-1:0]   rdata,
  output logic                resp_valid,
  output logic                resp_is_store,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                ale,
  output logic [ADDR_W-1:0]   ale_badv,
  output logic                busy
);
  localparam int SW = DATA_W / 8;
  localparam int OW = $clog2(SW);
  localparam int CW = $clog2(MAX_OUTST + 1);
  localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  logic [CW-1:0] r_outst, r_disc, w_outst_nxt;
  logic [OW:0]   r_tag [MAX_OUTST];
  logic [PW-1:0] r_wp, r_rp;
  logic          w_accept, w_pop, w_ale, w_resp;
  logic [7:0]    w_mask8;
  logic [SW-1:0] w_mask;
  logic [OW-1:0] w_off;
  logic [OW:0]   w_tag;

  function automatic logic [PW-1:0] f_nxt(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
  endfunction

`ifdef MEM_ALE_CHECK_EN
  assign w_ale = ex_valid & ((ex_size == 2'd1 & ex_addr[0]) | (ex_size == 2'd2 & |ex_addr[1:0]) |
                             (ex_size == 2'd3 & |ex_addr[2:0]));
  assign ale_badv = w_ale ? ex_addr : '0;
`else
  assign w_ale    = 1'b0;
  assign ale_badv = '0;
`endif

  assign ale         = w_ale;
  assign w_off       = ex_addr[OW-1:0];
  assign req         = ex_valid & ~ex_cancel & ~w_ale & (r_outst < CW'(MAX_OUTST));
  assign w_accept    = req & addr_ok;
  assign ex_ready    = w_accept | (ex_valid & w_ale & ~ex_cancel);
  assign w_pop       = data_ok & (r_outst != '0);
  assign w_resp      = w_pop & (r_disc == '0) & ~ex_cancel;
  assign w_outst_nxt = r_outst + CW'(w_accept) - CW'(w_pop);
  assign w_tag       = r_tag[r_rp];
  assign busy        = (r_outst != '0) | (r_disc != '0);
  assign wr          = ex_valid & ex_is_store;
  assign size        = ex_size;
  assign addr        = ex_addr & ~ADDR_W'(SW - 1);

  always_comb begin
    w_mask8 = ex_size == 2'd0 ? 8'h01 : ex_size == 2'd1 ? 8'h03 : ex_size == 2'd2 ? 8'h0F : 8'hFF;
    w_mask  = w_mask8[SW-1:0];
    wstrb   = wr ? w_mask << w_off : '0;
    wdata   = ex_size == 2'd0 ? {SW{ex_wdata[7:0]}} :
              ex_size == 2'd1 ? {(DATA_W/16){ex_wdata[15:0]}} :
              ex_size == 2'd2 ? {(DATA_W/32){ex_wdata[31:0]}} : ex_wdata;
  end

  always_ff @(posedge clk)
    if (w_accept) r_tag[r_wp] <= {ex_is_store, w_off};

  // A flush discards whatever is still outstanding after this cycle's accept/pop.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_outst       <= '0;
      r_disc        <= '0;
      r_wp          <= '0;
      r_rp          <= '0;
      resp_valid    <= 1'b0;
      resp_is_store <= 1'b0;
      resp_rdata    <= '0;
    end else begin
      r_outst    <= w_outst_nxt;
      r_disc     <= ex_cancel ? w_outst_nxt : (w_pop && r_disc != '0) ? r_disc - 1'b1 : r_disc;
      resp_valid <= w_resp;
      if (w_accept) r_wp <= f_nxt(r_wp);
      if (w_pop) r_rp <= f_nxt(r_rp);
      if (w_resp) begin
        resp_is_store <= w_tag[OW];
        resp_rdata    <= rdata >> {w_tag[OW-1:0], 3'b000};
      end
    end
  end
endmodule

// File: tb/tb_ex_mem_req_ctrl.sv
// tb_ex_mem_req_ctrl: directed and random checks of ex_mem_req_ctrl against a queue-based reference model.
module tb_ex_mem_req_ctrl;
  localparam int MAXO = 2;
`ifdef MEM_ALE_CHECK_EN
  localparam bit ALE_EN = 1'b1;
`else
  localparam bit ALE_EN = 1'b0;
`endif
  typedef struct {bit st; int unsigned off;} tag_t;

  logic clk = 1'b0, resetn = 1'b0;
  logic ex_valid = 0, ex_is_store = 0, ex_cancel = 0, addr_ok = 0, data_ok = 0;
  logic [1:0] ex_size = 0;
  logic [31:0] ex_addr = 0, ex_wdata = 0, rdata = 0;
  logic ex_ready, req, wr, resp_valid, resp_is_store, ale, busy;
  logic [1:0] size;
  logic [3:0] wstrb;
  logic [31:0] addr, wdata, resp_rdata, ale_badv;
  int checks = 0, errors = 0;
  tag_t q[$];
  int disc = 0;
  bit e_rv, e_st;
  logic [31:0] e_rd;

  always #5 clk = ~clk;

  ex_mem_req_ctrl #(.DATA_W(32), .ADDR_W(32), .MAX_OUTST(MAXO)) dut (
    .clk(clk), .resetn(resetn), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_is_store(ex_is_store),
    .ex_size(ex_size), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_cancel(ex_cancel), .req(req), .wr(wr),
    .size(size), .wstrb(wstrb), .addr(addr), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok),
    .rdata(rdata), .resp_valid(resp_valid), .resp_is_store(resp_is_store), .resp_rdata(resp_rdata),
    .ale(ale), .ale_badv(ale_badv), .busy(busy));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    bit ale_m, e_req, acc, pop;
    logic [3:0] e_strb;
    logic [31:0] e_wd;
    tag_t t;
    #1;
    e_rv = 0;
    if (resetn) begin
      ale_m = ALE_EN && ex_valid && (ex_addr % (32'd1 << ex_size)) != 0;
      e_req = ex_valid && !ex_cancel && !ale_m && q.size() < MAXO;
      acc   = e_req && addr_ok;
      pop   = data_ok && q.size() > 0;
      chk("req", req, e_req);
      chk("ex_ready", ex_ready, acc || (ex_valid && ale_m && !ex_cancel));
      chk("ale", ale, ale_m);
      chk("ale_badv", ale_badv, ale_m ? ex_addr : 32'd0);
      chk("wr", wr, ex_valid && ex_is_store);
      chk("size", size, ex_size);
      e_strb = (ex_valid && ex_is_store) ? 4'(((1 << (1 << ex_size)) - 1) << (ex_addr % 4)) : 4'd0;
      chk("wstrb", wstrb, e_strb);
      if (ex_valid) begin
        chk("addr", addr, ex_addr & ~32'd3);
        for (int i = 0; i < 4; i++) e_wd[8*i +: 8] = ex_wdata[8*(i % (1 << ex_size)) +: 8];
        chk("wdata", wdata, e_wd);
      end
      if (pop) begin
        t = q.pop_front();
        if (disc == 0 && !ex_cancel) begin
          e_rv = 1; e_st = t.st; e_rd = rdata >> (8 * t.off);
        end
      end
      if (acc) q.push_back('{ex_is_store, ex_addr % 4});
      if (ex_cancel) disc = q.size();
      else if (pop && disc > 0) disc--;
    end else begin
      q.delete();
      disc = 0;
    end
    @(posedge clk);
    #1;
    chk("resp_valid", resp_valid, e_rv);
    if (e_rv) begin
      chk("resp_rdata", resp_rdata, e_rd);
      chk("resp_is_store", resp_is_store, e_st);
    end
    if (!resetn) chk("rst_rdata", resp_rdata, 32'd0);
    chk("busy", busy, q.size() != 0 || disc != 0);
  endtask

  task automatic drv(input bit v, input bit st, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                     input bit cn, input bit aok, input bit dok, input logic [31:0] rd);
    ex_valid = v; ex_is_store = st; ex_size = sz; ex_addr = a; ex_wdata = wd;
    ex_cancel = cn; addr_ok = aok; data_ok = dok; rdata = rd;
    cyc();
  endtask

  initial begin
    resetn = 0;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF);
    resetn = 1;
    drv(0, 0, 0, 0, 0, 0, 0, 1, 32'h1111_1111);
    // load word, answered three cycles later
    drv(1, 0, 2, 32'h1000, 0, 0, 1, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 1, 32'hAABB_CCDD);
    chk("t1_rdata", resp_rdata, 32'hAABB_CCDD);
    // byte store then half load
    drv(1, 1, 0, 32'h2003, 32'h5A, 0, 1, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("t2_store_resp", resp_is_store, 1'b1);
    drv(1, 0, 1, 32'h2002, 0, 0, 1, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 1, 32'h1234_5678);
    chk("t2_rdata", resp_rdata, 32'h0000_1234);
    // full blocks the third load, even with data_ok in the same cycle
    drv(1, 0, 2, 32'h3000, 0, 0, 1, 0, 0);
    drv(1, 0, 2, 32'h3004, 0, 0, 1, 0, 0);
    drv(1, 0, 2, 32'h3008, 0, 0, 1, 0, 0);
    drv(1, 0, 2, 32'h3008, 0, 0, 1, 1, 32'h0A);
    drv(1, 0, 2, 32'h3008, 0, 0, 1, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 1, 32'h0B);
    drv(0, 0, 0, 0, 0, 0, 0, 1, 32'h0C);
    // flush with two in flight
    drv(1, 0, 2, 32'h4000, 0, 0, 1, 0, 0);
    drv(1, 0, 2, 32'h4004, 0, 0, 1, 0, 0);
    drv(1, 0, 2, 32'h4008, 0, 1, 1, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 1, 32'h01);
    drv(1, 0, 0, 32'h4001, 0, 0, 1, 1, 32'h02);
    drv(0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_7700);
    chk("t4_rdata", resp_rdata, 32'h77);
    // cancel coinciding with the only data_ok
    drv(1, 0, 2, 32'h5000, 0, 0, 1, 0, 0);
    drv(0, 0, 0, 0, 0, 1, 0, 1, 32'h55);
    chk("t5_busy", busy, 1'b0);
    // misaligned word load
    drv(1, 0, 2, 32'h1002, 0, 0, 1, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    drv(0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    for (int i = 0; i < 600; i++) begin
      resetn = ($urandom_range(0, 99) != 0);
      drv($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 2)), $urandom,
          $urandom, $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
